// File: rtl/i2c_xfer_arbiter.sv
// Round-robin arbiter granting one requester at a time a single-byte I2C transfer on a shared byte engine.
// Start 2 cycles after a request is sampled; holds in ISSUE while eng_ready=0; WAIT aborts after TIMEOUT_CYC cycles.
module i2c_xfer_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [7*NUM_REQ-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]     req_rw,
  input  logic [8*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic [7:0]             rdata,
  output logic [1:0]             err,
  output logic                   eng_start,
  output logic [6:0]             eng_addr,
  output logic                   eng_rw,
  output logic [7:0]             eng_wdata,
  output logic                   eng_abort,
  input  logic                   eng_ready,
  input  logic                   eng_done,
  input  logic                   eng_nack,
  input  logic [7:0]             eng_rdata
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [7:0]           rdata_q, rdata_d;
  logic [1:0]           err_q, err_d;
  logic [6:0]           addr_q, addr_d;
  logic                 rw_q, rw_d;
  logic [7:0]           wdata_q, wdata_d;

  logic [6:0]           addr_a  [NUM_REQ];
  logic [7:0]           wdata_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g]  = req_addr[7*g +: 7];
    assign wdata_a[g] = req_wdata[8*g +: 8];
  end

  // Round-robin search: first asserted request at or above ptr, wrapping.
  logic                 win_vld;
  logic [IW-1:0]        win_idx;
  logic [IW:0]          rr_sum;
  logic [IW-1:0]        rr_idx;

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    rr_sum  = '0;
    rr_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rr_sum = {1'b0, ptr_q} + (IW+1)'(i);
      if (rr_sum >= (IW+1)'(NUM_REQ)) begin
        rr_sum = rr_sum - (IW+1)'(NUM_REQ);
      end
      rr_idx = rr_sum[IW-1:0];
      if (!win_vld && req[rr_idx]) begin
        win_vld = 1'b1;
        win_idx = rr_idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    wdata_d   = wdata_q;
    eng_start = 1'b0;
    eng_abort = 1'b0;
    done      = '0;

    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d = S_GRANT;
          idx_d   = win_idx;
          gnt_d   = NUM_REQ'(1) << win_idx;
          addr_d  = addr_a[win_idx];
          rw_d    = req_rw[win_idx];
          wdata_d = wdata_a[win_idx];
        end
      end

      S_GRANT: begin
        state_d = S_ISSUE;
      end

      S_ISSUE: begin
        if (eng_ready) begin
          eng_start = 1'b1;
          cnt_d     = '0;
          state_d   = S_WAIT;
        end
      end

      // A completion on the last counted cycle beats the timeout.
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (eng_done) begin
          state_d = S_RESP;
          err_d   = eng_nack ? 2'b01 : 2'b00;
          if (rw_q) begin
            rdata_d = eng_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          eng_abort = 1'b1;
          err_d     = 2'b10;
          state_d   = S_RESP;
        end
      end

      S_RESP: begin
        done    = gnt_q;
        ptr_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
        gnt_d   = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
    end
  end

  assign gnt       = gnt_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign eng_addr  = addr_q;
  assign eng_rw    = rw_q;
  assign eng_wdata = wdata_q;

`ifndef SYNTHESIS
  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_done_granted: assert property (@(posedge clk) disable iff (!rst_n) (done & ~gnt) == '0);
`endif

endmodule

// File: tb/tb_i2c_xfer_arbiter.sv
// Bench for i2c_xfer_arbiter: transaction-timeline model checked every cycle, plus directed scenarios.
module tb_i2c_xfer_arbiter;
  localparam int N = 4;
  localparam int T = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [7*N-1:0] req_addr = '0;
  logic [N-1:0]   req_rw = '0;
  logic [8*N-1:0] req_wdata = '0;
  logic [N-1:0]   gnt, done;
  logic [7:0]     rdata;
  logic [1:0]     err;
  logic           eng_start, eng_rw, eng_abort;
  logic [6:0]     eng_addr;
  logic [7:0]     eng_wdata;
  logic           eng_ready = 1'b1;
  logic           eng_done = 1'b0;
  logic           eng_nack = 1'b0;
  logic [7:0]     eng_rdata = '0;

  i2c_xfer_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .err(err),
    .eng_start(eng_start), .eng_addr(eng_addr), .eng_rw(eng_rw), .eng_wdata(eng_wdata),
    .eng_abort(eng_abort), .eng_ready(eng_ready), .eng_done(eng_done),
    .eng_nack(eng_nack), .eng_rdata(eng_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Engine stand-in: eng_done eng_lat cycles after eng_start (0 = never), plus stray pulses.
  int eng_lat = 0;
  int eng_cnt = 0;
  bit spur = 1'b0;
  initial forever begin
    @(posedge clk); #1;
    eng_done = spur;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) eng_done = 1'b1;
    end
    @(negedge clk);
    if (!rst_n) eng_cnt = 0;
    else if (eng_start && eng_lat > 0) eng_cnt = eng_lat;
  end

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  // Model: a transfer is a timeline of grant, start, finish and done cycles.
  bit         m_busy = 0, m_started = 0, m_fin = 0;
  int         m_ptr = 0, m_idx = 0, m_gcyc = 0, m_scyc = 0, m_dcyc = 0;
  logic [6:0] m_addr;
  logic       m_rw;
  logic [7:0] m_wdata, m_rdata = '0, m_rdata_n;
  logic [1:0] m_err_n;

  int         start_cnt = 0, done_cnt = 0, abort_cnt = 0;
  int         start_cyc = 0, done_cyc = 0, abort_cyc = 0;
  logic [6:0] st_addr;
  logic [7:0] st_wdata;
  logic [N-1:0] done_vec, prev_gnt = '0;
  logic [1:0] done_err;
  logic [7:0] done_rdata;
  int         glog[$];
  int         gcyc_log[$];

  always @(negedge clk) begin
    logic [N-1:0] exp_gnt, exp_done;
    logic         exp_start, exp_abort;
    if (!rst_n) begin
      chk("rst_gnt", gnt, 0);
      chk("rst_done", done, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_err", err, 0);
      chk("rst_start", eng_start, 0);
      chk("rst_abort", eng_abort, 0);
      chk("rst_eaddr", eng_addr, 0);
      chk("rst_erw", eng_rw, 0);
      chk("rst_ewdata", eng_wdata, 0);
      m_busy = 0; m_ptr = 0; m_rdata = '0; prev_gnt = '0;
    end else begin
      exp_gnt = '0; exp_done = '0; exp_start = 1'b0; exp_abort = 1'b0;
      if (m_busy) begin
        exp_gnt = N'(1) << m_idx;
        if (cyc == m_gcyc) begin
          exp_start = 1'b0;
        end else if (!m_started) begin
          exp_start = eng_ready;
          if (eng_ready) begin
            m_started = 1; m_scyc = cyc;
            chk("start_addr", eng_addr, m_addr);
            chk("start_rw", eng_rw, m_rw);
            chk("start_wdata", eng_wdata, m_wdata);
          end
        end else if (!m_fin) begin
          if (eng_done) begin
            m_fin = 1; m_dcyc = cyc + 1;
            m_err_n = eng_nack ? 2'b01 : 2'b00;
            m_rdata_n = m_rw ? eng_rdata : m_rdata;
          end else if (cyc - m_scyc == T) begin
            exp_abort = 1'b1;
            m_fin = 1; m_dcyc = cyc + 1;
            m_err_n = 2'b10; m_rdata_n = m_rdata;
          end
        end else if (cyc == m_dcyc) begin
          exp_done = N'(1) << m_idx;
          m_rdata = m_rdata_n;
          chk("done_err", err, m_err_n);
          m_busy = 0;
          m_ptr = (m_idx + 1) % N;
        end
      end else if (req != '0) begin
        m_busy = 1; m_started = 0; m_fin = 0;
        m_gcyc = cyc + 1;
        m_idx = rr_pick(req, m_ptr);
        m_addr = req_addr[7*m_idx +: 7];
        m_rw = req_rw[m_idx];
        m_wdata = req_wdata[8*m_idx +: 8];
      end
      chk("gnt", gnt, exp_gnt);
      chk("done", done, exp_done);
      chk("eng_start", eng_start, exp_start);
      chk("eng_abort", eng_abort, exp_abort);
      chk("rdata", rdata, m_rdata);

      if (eng_start) begin start_cnt++; start_cyc = cyc; st_addr = eng_addr; st_wdata = eng_wdata; end
      if (eng_abort) begin abort_cnt++; abort_cyc = cyc; end
      if (done != '0) begin done_cnt++; done_cyc = cyc; done_vec = done; done_err = err; done_rdata = rdata; end
      if (prev_gnt == '0 && gnt != '0) begin
        for (int i = 0; i < N; i++) if (gnt[i]) glog.push_back(i);
        gcyc_log.push_back(cyc);
      end
      prev_gnt = gnt;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_req(input int i, input logic [6:0] a, input logic rw, input logic [7:0] wd);
    req_addr[7*i +: 7] = a;
    req_rw[i] = rw;
    req_wdata[8*i +: 8] = wd;
    req[i] = 1'b1;
  endtask

  task automatic wait_done(input int target, input int limit, input string nm);
    int k = 0;
    while (done_cnt < target && k < limit) begin @(negedge clk); #1; k++; end
    if (done_cnt < target) begin
      checks++; errors++;
      $display("FAIL %s: done count %0d after %0d cycles, required %0d", nm, done_cnt, limit, target);
    end
  endtask

  task automatic wait_start(input int target, input int limit, input string nm);
    int k = 0;
    while (start_cnt < target && k < limit) begin @(negedge clk); #1; k++; end
    if (start_cnt < target) begin
      checks++; errors++;
      $display("FAIL %s: start count %0d after %0d cycles, required %0d", nm, start_cnt, limit, target);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, t, s0, d0, a0;
    int ord[5] = '{0, 1, 2, 3, 0};
    int ord8[2] = '{0, 2};

    tick(3);
    rst_n = 1'b1;
    tick(1);
    chk("post_rst_gnt", gnt, 0);

    // Single write from requester 1
    eng_lat = 10; eng_nack = 1'b0;
    set_req(1, 7'h50, 1'b0, 8'hA5);
    r = cyc; t = done_cnt;
    wait_done(t + 1, 40, "t1_wait");
    tick(1); req = '0;
    chk("t1_latency", start_cyc - r, 2);
    chk("t1_addr", st_addr, 7'h50);
    chk("t1_wdata", st_wdata, 8'hA5);
    chk("t1_done_vec", done_vec, 4'b0010);
    chk("t1_err", done_err, 2'b00);
    chk("t1_duration", done_cyc - start_cyc, 11);

    // Read with nack from requester 0
    eng_lat = 3; eng_nack = 1'b1; eng_rdata = 8'h77;
    set_req(0, 7'h3C, 1'b1, 8'h00);
    t = done_cnt;
    wait_done(t + 1, 40, "t2_wait");
    tick(1); req = '0; eng_nack = 1'b0;
    chk("t2_addr", st_addr, 7'h3C);
    chk("t2_done_vec", done_vec, 4'b0001);
    chk("t2_err", done_err, 2'b01);
    chk("t2_rdata", done_rdata, 8'h77);

    // Fairness from a fresh pointer, all requesters held
    rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(1);
    glog.delete(); gcyc_log.delete();
    eng_lat = 2;
    for (int i = 0; i < N; i++) set_req(i, 7'(7'h10 + i), 1'(i % 2), 8'(8'h20 + i));
    t = done_cnt;
    wait_done(t + 5, 80, "t3_wait");
    tick(1); req = '0;
    chk("t3_grants", glog.size(), 5);
    for (int k = 0; k < 5; k++) if (k < glog.size()) chk($sformatf("t3_order%0d", k), glog[k], ord[k]);
    for (int k = 1; k < 5; k++) if (k < gcyc_log.size()) chk($sformatf("t3_gap%0d", k), gcyc_log[k] - gcyc_log[k-1], 6);

    // Timeout: engine never completes
    eng_lat = 0;
    set_req(2, 7'h22, 1'b0, 8'h99);
    t = done_cnt;
    wait_done(t + 1, 60, "t4_wait");
    tick(1); req = '0;
    chk("t4_abort_delay", abort_cyc - start_cyc, 16);
    chk("t4_done_after_abort", done_cyc - abort_cyc, 1);
    chk("t4_done_vec", done_vec, 4'b0100);
    chk("t4_err", done_err, 2'b10);
    chk("t4_rdata_kept", done_rdata, 8'h77);

    // Completion on the timeout cycle
    eng_lat = 16; eng_nack = 1'b1; eng_rdata = 8'h5A;
    set_req(3, 7'h33, 1'b1, 8'h00);
    a0 = abort_cnt; t = done_cnt;
    wait_done(t + 1, 60, "t5_wait");
    tick(1); req = '0; eng_nack = 1'b0;
    chk("t5_no_abort", abort_cnt, a0);
    chk("t5_duration", done_cyc - start_cyc, 17);
    chk("t5_done_vec", done_vec, 4'b1000);
    chk("t5_err", done_err, 2'b01);
    chk("t5_rdata", done_rdata, 8'h5A);

    // Stray eng_done while idle
    s0 = start_cnt; d0 = done_cnt;
    @(negedge clk); #1; spur = 1'b1;
    @(negedge clk); #1; spur = 1'b0;
    tick(3);
    chk("t6_no_done", done_cnt, d0);
    chk("t6_no_start", start_cnt, s0);

    // Reset during WAIT, then engine busy after release
    eng_lat = 0;
    set_req(0, 7'h01, 1'b0, 8'h11);
    wait_start(s0 + 1, 20, "t7_start");
    tick(3);
    rst_n = 1'b0; eng_ready = 1'b0; req = '0;
    tick(2);
    s0 = start_cnt; d0 = done_cnt; a0 = abort_cnt;
    rst_n = 1'b1;
    set_req(2, 7'h2A, 1'b1, 8'h00);
    tick(10);
    chk("t7_gnt_held", gnt, 4'b0100);
    chk("t7_no_start", start_cnt, s0);
    chk("t7_no_done", done_cnt, d0);
    chk("t7_no_abort", abort_cnt, a0);
    eng_lat = 4; eng_rdata = 8'hC3; eng_nack = 1'b0; eng_ready = 1'b1;
    r = cyc;
    wait_done(d0 + 1, 40, "t7_wait");
    tick(1); req = '0;
    chk("t7_start_on_ready", start_cyc - r, 0);
    chk("t7_done_vec", done_vec, 4'b0100);
    chk("t7_rdata", done_rdata, 8'hC3);

    // Pointer wrap and a request dropped mid-transfer
    glog.delete();
    eng_lat = 5;
    set_req(0, 7'h44, 1'b0, 8'h66);
    set_req(2, 7'h55, 1'b0, 8'h77);
    t = done_cnt;
    tick(2); req[0] = 1'b0;
    wait_done(t + 2, 60, "t8_wait");
    tick(1); req = '0;
    chk("t8_grants", glog.size(), 2);
    for (int k = 0; k < 2; k++) if (k < glog.size()) chk($sformatf("t8_order%0d", k), glog[k], ord8[k]);

    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_xfer_arbiter.md
I2C_XFER_ARBITER -- requirements
Module: i2c_xfer_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter TIMEOUT_CYC, default 1024, max clk cycles in WAIT before abort (>=4).
REQ-003 Port clk  input  1  system clock, all logic on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port req  input  NUM_REQ  per-requester transfer request, level, held until done.
REQ-006 Port req_addr  input  7*NUM_REQ  per-requester 7-bit target address, slice i = [7i+6:7i].
REQ-007 Port req_rw  input  NUM_REQ  per-requester direction, 1=read, 0=write.
REQ-008 Port req_wdata  input  8*NUM_REQ  per-requester write byte, slice i = [8i+7:8i].
REQ-009 Port gnt  output  NUM_REQ  one-hot grant, high from GRANT through RESP.
REQ-010 Port done  output  NUM_REQ  one-cycle completion pulse to granted requester.
REQ-011 Port rdata  output  8  read byte, valid with done, held until next done.
REQ-012 Port err  output  2  status, valid with done: 00 ok, 01 nack, 10 timeout.
REQ-013 Port eng_start  output  1  one-cycle start pulse to byte engine.
REQ-014 Port eng_addr / eng_rw / eng_wdata  output  7/1/8  latched transfer fields, stable from GRANT to IDLE.
REQ-015 Port eng_abort  output  1  one-cycle abort pulse to byte engine on timeout.
REQ-016 Port eng_ready  input  1  engine idle, may accept eng_start.
REQ-017 Port eng_done / eng_nack / eng_rdata  input  1/1/8  engine completion pulse, nack flag and read byte, sampled when eng_done=1.

Function
REQ-018 States IDLE, GRANT, ISSUE, WAIT, RESP; exactly one active.
REQ-019 IDLE: if any req bit high -> GRANT next cycle; else stay.
REQ-020 Arbitration round-robin: winner = first req bit at or above index ptr, wrapping NUM_REQ-1 -> 0; ptr resets to 0.
REQ-021 GRANT (1 cycle): gnt[winner]=1; latch winner's addr/rw/wdata into eng_* registers; -> ISSUE.
REQ-022 ISSUE: when eng_ready=1 drive eng_start=1 for that cycle, clear timeout counter, -> WAIT; else hold in ISSUE (no timeout in ISSUE).
REQ-023 Minimum latency req rising -> eng_start: 2 cycles (IDLE sample, GRANT, start in ISSUE cycle).
REQ-024 WAIT: timeout counter increments each cycle; eng_done=1 -> latch rdata=eng_rdata (read) or keep prior rdata (write), err=eng_nack?01:00, -> RESP.
REQ-025 WAIT: counter reaching TIMEOUT_CYC-1 without eng_done -> eng_abort=1 one cycle, err=10, rdata unchanged, -> RESP.
REQ-026 Simultaneous eng_done and timeout in same cycle: eng_done wins, no eng_abort.
REQ-027 RESP (1 cycle): done[granted]=1; ptr = (granted+1) mod NUM_REQ; -> IDLE; gnt cleared entering IDLE.
REQ-028 Back-to-back: a pending request is granted no earlier than the cycle after IDLE, so gnt is low >=1 cycle between grants.
REQ-029 req dropped by granted requester mid-transfer: transfer completes, done still pulsed; new req bits during transfer wait.
REQ-030 eng_done outside WAIT is ignored; eng_start never issued while not in ISSUE.
REQ-031 gnt and done are one-hot-or-zero at all times; done only asserted for the bit currently granted.

Reset
REQ-032 rst_n low asynchronously forces IDLE, ptr=0, counter=0, gnt=0, done=0, rdata=0, err=00, eng_start=0, eng_abort=0, eng_addr=0, eng_rw=0, eng_wdata=0.
REQ-033 Reset mid-transfer abandons it without eng_abort or done; first grant after release follows REQ-019/020 from ptr=0.

Verification
REQ-034 Single write: req[1]=1, addr 0x50, rw=0, wdata 0xA5, engine done after 10 cycles, nack=0 -> eng_start 2 cycles after req, eng_addr=0x50, eng_wdata=0xA5, done[1] pulse, err=00.
REQ-035 Read with nack: req[0] read addr 0x3C, eng_done with eng_nack=1, eng_rdata=0x77 -> done[0], err=01, rdata=0x77.
REQ-036 Fairness: req=4'b1111 held continuously -> grant order 0,1,2,3,0 with one IDLE cycle between grants.
REQ-037 Timeout: TIMEOUT_CYC=16, engine never returns eng_done -> eng_abort pulse 16 cycles after eng_start, done pulse, err=10.
REQ-038 Race: eng_done asserted on the timeout cycle -> no eng_abort, err from eng_nack.
REQ-039 Reset in WAIT, then eng_ready=0 held after release with req[2]=1 -> gnt[2] set, FSM stays in ISSUE, no done, no eng_start until eng_ready=1.
